// File: rtl/ctr_crd_arb.sv
// ctr_crd_arb: round-robin arbiter sharing the GLB coordinate read port
// between the FPS and KNN engines. A one-entry address stage feeds GLB,
// and an in-order tag FIFO records which engine owns each outstanding read
// so returned words are steered back combinationally.
// Optional build macro: CTR_CRD_ARB_PERF_EN adds saturating grant/stall counters.
module ctr_crd_arb #(
    parameter int SRAM_WIDTH = 256,
    parameter int IDX_WIDTH  = 10,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUCTR_Rst,
    input  logic [IDX_WIDTH-1:0]  FPSARB_CrdAddr,
    input  logic                  FPSARB_CrdAddrVld,
    output logic                  ARBFPS_CrdAddrRdy,
    output logic [SRAM_WIDTH-1:0] ARBFPS_Crd,
    output logic                  ARBFPS_CrdVld,
    input  logic                  FPSARB_CrdRdy,
    input  logic [IDX_WIDTH-1:0]  KNNARB_CrdAddr,
    input  logic                  KNNARB_CrdAddrVld,
    output logic                  ARBKNN_CrdAddrRdy,
    output logic [SRAM_WIDTH-1:0] ARBKNN_Crd,
    output logic                  ARBKNN_CrdVld,
    input  logic                  KNNARB_CrdRdy,
`ifdef CTR_CRD_ARB_PERF_EN
    output logic [15:0]           ARBCCU_FpsGntCnt,
    output logic [15:0]           ARBCCU_KnnGntCnt,
    output logic [15:0]           ARBCCU_StallCnt,
`endif
    output logic [IDX_WIDTH-1:0]  ARBGLB_CrdAddr,
    output logic                  ARBGLB_CrdAddrVld,
    input  logic                  GLBARB_CrdAddrRdy,
    input  logic [SRAM_WIDTH-1:0] GLBARB_Crd,
    input  logic                  GLBARB_CrdVld,
    output logic                  ARBGLB_CrdRdy
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(TAG_DEPTH);
    localparam logic [CW-1:0] CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ONE_C = {{(PW-1){1'b0}}, 1'b1};

    // Address stage
    logic                 stage_full_q, stage_full_d;
    logic [IDX_WIDTH-1:0] stage_addr_q, stage_addr_d;
    // Round-robin pointer: 0 = FPS has priority, 1 = KNN has priority
    logic                 prio_q, prio_d;
    // Tag FIFO: 0 = FPS owns the read, 1 = KNN owns it
    logic                 tag_q [TAG_DEPTH];
    logic                 tag_d [TAG_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic slot_free_s, room_s, accept_ok_s;
    logic gnt_fps_s, gnt_knn_s, push_s, pop_s;
    logic cnt_nz_s, head_s;

    // Arbitration, flow control and return-path steering
    always_comb begin
        cnt_nz_s    = (cnt_q != {CW{1'b0}});
        head_s      = tag_q[rd_ptr_q];
        ARBGLB_CrdRdy = cnt_nz_s & (head_s ? KNNARB_CrdRdy : FPSARB_CrdRdy);
        pop_s       = GLBARB_CrdVld & ARBGLB_CrdRdy;
        slot_free_s = ~stage_full_q | GLBARB_CrdAddrRdy;
        room_s      = (cnt_q < DEPTH_C) | pop_s;
        accept_ok_s = slot_free_s & room_s & ~CCUCTR_Rst;
        gnt_fps_s   = FPSARB_CrdAddrVld & (~KNNARB_CrdAddrVld | ~prio_q);
        gnt_knn_s   = KNNARB_CrdAddrVld & (~FPSARB_CrdAddrVld | prio_q);
        ARBFPS_CrdAddrRdy = accept_ok_s & gnt_fps_s;
        ARBKNN_CrdAddrRdy = accept_ok_s & gnt_knn_s;
        push_s      = ARBFPS_CrdAddrRdy | ARBKNN_CrdAddrRdy;
        ARBFPS_CrdVld = GLBARB_CrdVld & cnt_nz_s & ~head_s;
        ARBKNN_CrdVld = GLBARB_CrdVld & cnt_nz_s & head_s;
        ARBFPS_Crd    = GLBARB_Crd;
        ARBKNN_Crd    = GLBARB_Crd;
        ARBGLB_CrdAddrVld = stage_full_q;
        ARBGLB_CrdAddr    = stage_addr_q;
    end

    // Next-state for stage register, priority pointer and tag FIFO
    always_comb begin
        stage_full_d = stage_full_q;
        stage_addr_d = stage_addr_q;
        prio_d       = prio_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        if (CCUCTR_Rst) begin
            stage_full_d = 1'b0;
            stage_addr_d = {IDX_WIDTH{1'b0}};
            prio_d       = 1'b0;
            wr_ptr_d     = {PW{1'b0}};
            rd_ptr_d     = {PW{1'b0}};
            cnt_d        = {CW{1'b0}};
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_d[i] = 1'b0;
            end
        end else begin
            if (push_s) begin
                stage_full_d = 1'b1;
                stage_addr_d = gnt_fps_s ? FPSARB_CrdAddr : KNNARB_CrdAddr;
                prio_d       = gnt_fps_s;
                tag_d[wr_ptr_q] = ~gnt_fps_s;
                wr_ptr_d     = wr_ptr_q + PTR_ONE_C;
            end else if (stage_full_q & GLBARB_CrdAddrRdy) begin
                stage_full_d = 1'b0;
            end else begin
                stage_full_d = stage_full_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE_C;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE_C;
                2'b01:   cnt_d = cnt_q - CNT_ONE_C;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_full_q <= 1'b0;
            stage_addr_q <= {IDX_WIDTH{1'b0}};
            prio_q       <= 1'b0;
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= 1'b0;
            end
        end else begin
            stage_full_q <= stage_full_d;
            stage_addr_q <= stage_addr_d;
            prio_q       <= prio_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

`ifdef CTR_CRD_ARB_PERF_EN
    logic [15:0] fps_gnt_cnt_q, fps_gnt_cnt_d;
    logic [15:0] knn_gnt_cnt_q, knn_gnt_cnt_d;
    logic [15:0] stall_cnt_q,   stall_cnt_d;
    logic        stall_s;

    // Saturating grant and stall counters
    always_comb begin
        fps_gnt_cnt_d = fps_gnt_cnt_q;
        knn_gnt_cnt_d = knn_gnt_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        stall_s       = (FPSARB_CrdAddrVld | KNNARB_CrdAddrVld) & ~push_s;
        if (CCUCTR_Rst) begin
            fps_gnt_cnt_d = 16'h0000;
            knn_gnt_cnt_d = 16'h0000;
            stall_cnt_d   = 16'h0000;
        end else begin
            if (ARBFPS_CrdAddrRdy && (fps_gnt_cnt_q != 16'hFFFF)) begin
                fps_gnt_cnt_d = fps_gnt_cnt_q + 16'h0001;
            end else begin
                fps_gnt_cnt_d = fps_gnt_cnt_q;
            end
            if (ARBKNN_CrdAddrRdy && (knn_gnt_cnt_q != 16'hFFFF)) begin
                knn_gnt_cnt_d = knn_gnt_cnt_q + 16'h0001;
            end else begin
                knn_gnt_cnt_d = knn_gnt_cnt_q;
            end
            if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'h0001;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fps_gnt_cnt_q <= 16'h0000;
            knn_gnt_cnt_q <= 16'h0000;
            stall_cnt_q   <= 16'h0000;
        end else begin
            fps_gnt_cnt_q <= fps_gnt_cnt_d;
            knn_gnt_cnt_q <= knn_gnt_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ARBCCU_FpsGntCnt = fps_gnt_cnt_q;
    assign ARBCCU_KnnGntCnt = knn_gnt_cnt_q;
    assign ARBCCU_StallCnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ctr_crd_arb.sv
// Self-checking bench for ctr_crd_arb: a table of single-cycle vectors
// walked from reset, plus hand-written streaming, backpressure, soft-reset,
// async-reset and (with CTR_CRD_ARB_PERF_EN) counter sequences.
module tb_ctr_crd_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         CCUCTR_Rst;
    logic [9:0]   FPSARB_CrdAddr, KNNARB_CrdAddr;
    logic         FPSARB_CrdAddrVld, KNNARB_CrdAddrVld;
    logic         ARBFPS_CrdAddrRdy, ARBKNN_CrdAddrRdy;
    logic [255:0] ARBFPS_Crd, ARBKNN_Crd;
    logic         ARBFPS_CrdVld, ARBKNN_CrdVld;
    logic         FPSARB_CrdRdy, KNNARB_CrdRdy;
    logic [9:0]   ARBGLB_CrdAddr;
    logic         ARBGLB_CrdAddrVld;
    logic         GLBARB_CrdAddrRdy;
    logic [255:0] GLBARB_Crd;
    logic         GLBARB_CrdVld;
    logic         ARBGLB_CrdRdy;
`ifdef CTR_CRD_ARB_PERF_EN
    logic [15:0]  ARBCCU_FpsGntCnt, ARBCCU_KnnGntCnt, ARBCCU_StallCnt;
`endif

    int checks = 0;
    int errors = 0;

    ctr_crd_arb dut (
        .clk(clk), .rst_n(rst_n), .CCUCTR_Rst(CCUCTR_Rst),
        .FPSARB_CrdAddr(FPSARB_CrdAddr), .FPSARB_CrdAddrVld(FPSARB_CrdAddrVld),
        .ARBFPS_CrdAddrRdy(ARBFPS_CrdAddrRdy), .ARBFPS_Crd(ARBFPS_Crd),
        .ARBFPS_CrdVld(ARBFPS_CrdVld), .FPSARB_CrdRdy(FPSARB_CrdRdy),
        .KNNARB_CrdAddr(KNNARB_CrdAddr), .KNNARB_CrdAddrVld(KNNARB_CrdAddrVld),
        .ARBKNN_CrdAddrRdy(ARBKNN_CrdAddrRdy), .ARBKNN_Crd(ARBKNN_Crd),
        .ARBKNN_CrdVld(ARBKNN_CrdVld), .KNNARB_CrdRdy(KNNARB_CrdRdy),
`ifdef CTR_CRD_ARB_PERF_EN
        .ARBCCU_FpsGntCnt(ARBCCU_FpsGntCnt), .ARBCCU_KnnGntCnt(ARBCCU_KnnGntCnt),
        .ARBCCU_StallCnt(ARBCCU_StallCnt),
`endif
        .ARBGLB_CrdAddr(ARBGLB_CrdAddr), .ARBGLB_CrdAddrVld(ARBGLB_CrdAddrVld),
        .GLBARB_CrdAddrRdy(GLBARB_CrdAddrRdy), .GLBARB_Crd(GLBARB_Crd),
        .GLBARB_CrdVld(GLBARB_CrdVld), .ARBGLB_CrdRdy(ARBGLB_CrdRdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fv;  logic [9:0] fa;
        logic       kv;  logic [9:0] ka;
        logic       gar; logic       gv; logic [9:0] gd;
        logic       fr;  logic       kr; logic       sr;
        logic       e_far; logic e_kar; logic e_gav; logic [9:0] e_ga;
        logic       e_fcv; logic e_kcv; logic e_gcr;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [255:0] mk_data(input logic [9:0] a);
        return {16{6'h2A, a}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        CCUCTR_Rst = 1'b0;
        FPSARB_CrdAddrVld = 1'b0; FPSARB_CrdAddr = 10'h000;
        KNNARB_CrdAddrVld = 1'b0; KNNARB_CrdAddr = 10'h000;
        GLBARB_CrdAddrRdy = 1'b0; GLBARB_CrdVld = 1'b0; GLBARB_Crd = 256'h0;
        FPSARB_CrdRdy = 1'b0; KNNARB_CrdRdy = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_far"}, ARBFPS_CrdAddrRdy, 1'b0);
        chk({nm, "_kar"}, ARBKNN_CrdAddrRdy, 1'b0);
        chk({nm, "_gav"}, ARBGLB_CrdAddrVld, 1'b0);
        chk({nm, "_ga"},  ARBGLB_CrdAddr, 10'h000);
        chk({nm, "_fcv"}, ARBFPS_CrdVld, 1'b0);
        chk({nm, "_kcv"}, ARBKNN_CrdVld, 1'b0);
        chk({nm, "_gcr"}, ARBGLB_CrdRdy, 1'b0);
    endtask

    task automatic soft_reset();
        @(negedge clk);
        idle_inputs();
        CCUCTR_Rst = 1'b1;
        @(negedge clk);
        CCUCTR_Rst = 1'b0;
    endtask

    // Streams nf FPS and nk KNN addresses through a GLB model that is always
    // address-ready and returns data two cycles after accepting an address.
    task automatic run_stream(input int nf, input int nk, input logic [9:0] fb, input logic [9:0] kb);
        logic [9:0] exp_q [$];
        int fi = 0, ki = 0, n_glb = 0, fr_cnt = 0, kr_cnt = 0;
        int first_c = 0, last_c = 0;
        logic p1_v = 1'b0, p2_v = 1'b0;
        logic [9:0] p1_a = 10'h000, p2_a = 10'h000;
        int bf = 0, bk = 0;
        bit turn_k = 1'b0;
        while (bf < nf || bk < nk) begin
            if (bf < nf && (bk >= nk || !turn_k)) begin
                exp_q.push_back(fb + 10'(bf)); bf++;
            end else begin
                exp_q.push_back(kb + 10'(bk)); bk++;
            end
            turn_k = !turn_k;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            FPSARB_CrdAddrVld = (fi < nf); FPSARB_CrdAddr = fb + 10'(fi);
            KNNARB_CrdAddrVld = (ki < nk); KNNARB_CrdAddr = kb + 10'(ki);
            GLBARB_CrdAddrRdy = 1'b1; FPSARB_CrdRdy = 1'b1; KNNARB_CrdRdy = 1'b1;
            GLBARB_CrdVld = p2_v; GLBARB_Crd = mk_data(p2_a);
            #1;
            if (ARBFPS_CrdAddrRdy) fi++;
            if (ARBKNN_CrdAddrRdy) ki++;
            if (ARBGLB_CrdAddrVld) begin
                if (n_glb < exp_q.size()) chk("stream_glb_addr", ARBGLB_CrdAddr, exp_q[n_glb]);
                else chk("stream_glb_extra", 1'b1, 1'b0);
                if (n_glb == 0) first_c = cyc;
                last_c = cyc;
                n_glb++;
            end
            if (ARBFPS_CrdVld) begin
                chk("stream_fps_data", ARBFPS_Crd, mk_data(fb + 10'(fr_cnt)));
                fr_cnt++;
            end
            if (ARBKNN_CrdVld) begin
                chk("stream_knn_data", ARBKNN_Crd, mk_data(kb + 10'(kr_cnt)));
                kr_cnt++;
            end
            p2_v = p1_v; p2_a = p1_a;
            p1_v = ARBGLB_CrdAddrVld; p1_a = ARBGLB_CrdAddr;
        end
        chk("stream_glb_count", 32'(n_glb), 32'(nf + nk));
        chk("stream_consecutive", 32'(last_c - first_c), 32'(nf + nk - 1));
        chk("stream_fps_count", 32'(fr_cnt), 32'(nf));
        chk("stream_knn_count", 32'(kr_cnt), 32'(nk));
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        //           fv    fa      kv    ka      gar   gv    gd      fr    kr    sr  | far  kar  gav  ga      fcv  kcv  gcr
        vecs[0]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 10'h011, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 10'h012, 1'b1, 10'h021, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h011, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 10'h012, 1'b1, 10'h022, 1'b0, 1'b1, 10'h0A1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h021, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 10'h012, 1'b0, 10'h000, 1'b1, 1'b1, 10'h0B2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h021, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 10'h0B2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h012, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 10'h000, 1'b1, 10'h023, 1'b1, 1'b1, 10'h0C3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h012, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 10'h014, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h023, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 10'h015, 1'b1, 10'h025, 1'b1, 1'b1, 10'h0DD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h015, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, 10'h0E5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h015, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, 10'h077, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h015, 1'b0, 1'b0, 1'b0};

        // Power-on reset
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk_all_zero("post_reset");

        // Vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            FPSARB_CrdAddrVld = vecs[i].fv; FPSARB_CrdAddr = vecs[i].fa;
            KNNARB_CrdAddrVld = vecs[i].kv; KNNARB_CrdAddr = vecs[i].ka;
            GLBARB_CrdAddrRdy = vecs[i].gar; GLBARB_CrdVld = vecs[i].gv;
            GLBARB_Crd = mk_data(vecs[i].gd);
            FPSARB_CrdRdy = vecs[i].fr; KNNARB_CrdRdy = vecs[i].kr;
            CCUCTR_Rst = vecs[i].sr;
            #1;
            chk($sformatf("vec%0d_far", i), ARBFPS_CrdAddrRdy, vecs[i].e_far);
            chk($sformatf("vec%0d_kar", i), ARBKNN_CrdAddrRdy, vecs[i].e_kar);
            chk($sformatf("vec%0d_gav", i), ARBGLB_CrdAddrVld, vecs[i].e_gav);
            chk($sformatf("vec%0d_ga", i),  ARBGLB_CrdAddr, vecs[i].e_ga);
            chk($sformatf("vec%0d_fcv", i), ARBFPS_CrdVld, vecs[i].e_fcv);
            chk($sformatf("vec%0d_kcv", i), ARBKNN_CrdVld, vecs[i].e_kcv);
            chk($sformatf("vec%0d_gcr", i), ARBGLB_CrdRdy, vecs[i].e_gcr);
            chk($sformatf("vec%0d_fcrd", i), ARBFPS_Crd, mk_data(vecs[i].gd));
            chk($sformatf("vec%0d_kcrd", i), ARBKNN_Crd, mk_data(vecs[i].gd));
        end
        @(negedge clk);
        idle_inputs();

        // FPS-only stream, then alternating stream from prio 0
        run_stream(8, 0, 10'h000, 10'h000);
        soft_reset();
        run_stream(4, 4, 10'h010, 10'h200);

        // Backpressure: stage + 3 tags fills TAG_DEPTH
        soft_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            FPSARB_CrdAddrVld = 1'b1; FPSARB_CrdAddr = 10'h030 + 10'(i);
            GLBARB_CrdAddrRdy = 1'b1; FPSARB_CrdRdy = 1'b1;
            #1;
            chk("fill_far", ARBFPS_CrdAddrRdy, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            FPSARB_CrdAddr = 10'h034; GLBARB_CrdAddrRdy = 1'b0;
            #1;
            chk("hold_gav", ARBGLB_CrdAddrVld, 1'b1);
            chk("hold_ga", ARBGLB_CrdAddr, 10'h033);
            chk("hold_far", ARBFPS_CrdAddrRdy, 1'b0);
        end
        @(negedge clk);
        GLBARB_CrdAddrRdy = 1'b1;
        #1;
        chk("full_no_room_far", ARBFPS_CrdAddrRdy, 1'b0);
        @(negedge clk);
        GLBARB_CrdVld = 1'b1; GLBARB_Crd = mk_data(10'h030);
        #1;
        chk("pushpop_gcr", ARBGLB_CrdRdy, 1'b1);
        chk("pushpop_fcv", ARBFPS_CrdVld, 1'b1);
        chk("pushpop_far", ARBFPS_CrdAddrRdy, 1'b1);
        @(negedge clk);
        GLBARB_CrdVld = 1'b0; GLBARB_CrdAddrRdy = 1'b0; FPSARB_CrdAddr = 10'h035;
        #1;
        chk("after_pushpop_far", ARBFPS_CrdAddrRdy, 1'b0);
        chk("after_pushpop_ga", ARBGLB_CrdAddr, 10'h034);

        // Soft reset with outstanding tags and prio at KNN
        @(negedge clk);
        idle_inputs();
        CCUCTR_Rst = 1'b1;
        @(negedge clk);
        CCUCTR_Rst = 1'b0;
        FPSARB_CrdAddrVld = 1'b1; FPSARB_CrdAddr = 10'h040;
        KNNARB_CrdAddrVld = 1'b1; KNNARB_CrdAddr = 10'h240;
        FPSARB_CrdRdy = 1'b1; KNNARB_CrdRdy = 1'b1;
        #1;
        chk("srst_gav", ARBGLB_CrdAddrVld, 1'b0);
        chk("srst_gcr", ARBGLB_CrdRdy, 1'b0);
        chk("srst_prio_far", ARBFPS_CrdAddrRdy, 1'b1);
        chk("srst_prio_kar", ARBKNN_CrdAddrRdy, 1'b0);

        // Async reset in the middle of a transfer
        @(negedge clk);
        FPSARB_CrdAddrVld = 1'b0; KNNARB_CrdAddrVld = 1'b0;
        GLBARB_CrdVld = 1'b1; GLBARB_Crd = mk_data(10'h040);
        #1;
        chk("pre_arst_gav", ARBGLB_CrdAddrVld, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

`ifdef CTR_CRD_ARB_PERF_EN
        soft_reset();
        @(negedge clk);
        FPSARB_CrdAddrVld = 1'b1; GLBARB_CrdAddrRdy = 1'b1;
        FPSARB_CrdRdy = 1'b1; KNNARB_CrdRdy = 1'b1;
        repeat (4) begin
            @(negedge clk);
            GLBARB_CrdAddrRdy = 1'b0;
        end
        @(negedge clk);
        KNNARB_CrdAddrVld = 1'b1; GLBARB_CrdAddrRdy = 1'b1; GLBARB_CrdVld = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        KNNARB_CrdAddrVld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("perf_fps", ARBCCU_FpsGntCnt, 16'd5);
        chk("perf_knn", ARBCCU_KnnGntCnt, 16'd3);
        chk("perf_stall", ARBCCU_StallCnt, 16'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
